// File: rtl/dpdm_nrzi_decode.sv
// dpdm_nrzi_decode: USB receive-side line decoder.
// Registers DP/DM once per clock, classifies J/K/SE0/SE1, locks onto SYNC,
// NRZI-decodes the packet body (still bit-stuffed) and detects EOP.
// Build option: DPDM_RX_SYNC_STRIP_EN -- when defined the SYNC pattern is
// consumed silently; when undefined the eight SYNC bits are also emitted.
module dpdm_nrzi_decode #(
  parameter int MAX_BITS = 600
) (
  input  logic clock,
  input  logic reset_n,
  input  logic DP,
  input  logic DM,
  input  logic rx_enable,
  output logic out_bit,
  output logic out_valid,
  output logic rx_sending,
  output logic pkt_done,
  output logic rx_error
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] BIT_LIMIT = CW'(MAX_BITS);

`ifdef DPDM_RX_SYNC_STRIP_EN
  localparam logic EMIT_SYNC = 1'b0;
`else
  localparam logic EMIT_SYNC = 1'b1;
`endif

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR} state_t;

  state_t          state, state_next;
  logic            dp_q, dm_q;
  logic            prev_j, prev_j_next;     // last J/K seen: 1 = J, 0 = K
  logic [2:0]      sync_idx, sync_idx_next; // next expected sync bit (1..7)
  logic [2:0]      j_run, j_run_next;       // consecutive J samples in ERR
  logic [CW-1:0]   bit_cnt, bit_cnt_next;   // post-SYNC bits emitted
  logic            bit_next, valid_next, done_next, err_next;

  logic is_j, is_k, is_se0, is_jk, dec;

  assign is_j   = dp_q & ~dm_q;
  assign is_k   = ~dp_q & dm_q;
  assign is_se0 = ~dp_q & ~dm_q;
  assign is_jk  = is_j | is_k;
  // NRZI: no transition decodes as 1, transition as 0
  assign dec    = (dp_q == prev_j);

  assign rx_sending = (state == DATA);

  // Single input register stage; idles at J
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dp_q <= 1'b1;
      dm_q <= 1'b0;
    end else begin
      dp_q <= DP;
      dm_q <= DM;
    end
  end

  // Next-state, counters and output decisions from the registered line state
  always_comb begin
    state_next    = state;
    sync_idx_next = sync_idx;
    j_run_next    = j_run;
    bit_cnt_next  = bit_cnt;
    bit_next      = 1'b0;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (!rx_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // first K is sync bit 0, which always decodes as 0 against J
          if (is_k) begin
            state_next    = SYNC;
            sync_idx_next = 3'd1;
            valid_next    = EMIT_SYNC;
          end
        end
        SYNC: begin
          if (is_jk && (dec == (sync_idx == 3'd7))) begin
            valid_next = EMIT_SYNC;
            bit_next   = EMIT_SYNC & dec;
            if (sync_idx == 3'd7) begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end else begin
              sync_idx_next = sync_idx + 3'd1;
            end
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
            j_run_next = 3'd0;
          end
        end
        DATA: begin
          if (is_jk) begin
            if (bit_cnt == BIT_LIMIT) begin
              // one bit too many: drop it and flag the packet
              err_next   = 1'b1;
              state_next = ERR;
              j_run_next = 3'd0;
            end else begin
              valid_next   = 1'b1;
              bit_next     = dec;
              bit_cnt_next = bit_cnt + CW'(1);
            end
          end else if (is_se0) begin
            state_next = EOP1;
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
            j_run_next = 3'd0;
          end
        end
        EOP1: begin
          if (is_se0) begin
            state_next = EOP2;
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
            j_run_next = 3'd0;
          end
        end
        EOP2: begin
          if (is_j) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
            j_run_next = 3'd0;
          end
        end
        ERR: begin
          // need eight J samples in a row before listening again
          if (is_j) begin
            if (j_run == 3'd7) begin
              state_next = IDLE;
            end else begin
              j_run_next = j_run + 3'd1;
            end
          end else begin
            j_run_next = 3'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // NRZI reference returns to J whenever the decoder goes idle
    if (state_next == IDLE) begin
      prev_j_next = 1'b1;
    end else if (is_jk) begin
      prev_j_next = dp_q;
    end else begin
      prev_j_next = prev_j;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prev_j   <= 1'b1;
      sync_idx <= 3'd0;
      j_run    <= 3'd0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_next;
      prev_j   <= prev_j_next;
      sync_idx <= sync_idx_next;
      j_run    <= j_run_next;
      bit_cnt  <= bit_cnt_next;
    end
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      pkt_done  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      out_bit   <= bit_next;
      out_valid <= valid_next;
      pkt_done  <= done_next;
      rx_error  <= err_next;
    end
  end

endmodule

// File: tb/tb_dpdm_nrzi_decode.sv
// Bench for dpdm_nrzi_decode (MAX_BITS=16). Packets are described as data
// bits; the bench NRZI-encodes them onto DP/DM and records, per cycle, what
// the decoder must show two clocks later. A compare process checks every cycle.
module tb_dpdm_nrzi_decode;

  localparam int MB   = 16;
  localparam int NCYC = 2048;
`ifdef DPDM_RX_SYNC_STRIP_EN
  localparam int SV = 0;
`else
  localparam int SV = 8;
`endif
  localparam bit EMIT = (SV != 0);

  localparam logic [1:0] SJ = 2'b10;
  localparam logic [1:0] SK = 2'b01;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b11;

  logic clock = 1'b0;
  logic reset_n, DP, DM, rx_enable;
  logic out_bit, out_valid, rx_sending, pkt_done, rx_error;

  dpdm_nrzi_decode #(.MAX_BITS(MB)) dut (
    .clock(clock), .reset_n(reset_n), .DP(DP), .DM(DM), .rx_enable(rx_enable),
    .out_bit(out_bit), .out_valid(out_valid), .rx_sending(rx_sending),
    .pkt_done(pkt_done), .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit exp_v [0:NCYC-1];
  bit exp_b [0:NCYC-1];
  bit exp_s [0:NCYC-1];
  bit exp_d [0:NCYC-1];
  bit exp_e [0:NCYC-1];

  int total = 0;
  int bad = 0;
  int n_valid = 0, n_done = 0, n_err = 0;
  int b_v, b_d, b_e;
  logic [7:0] cap = 8'h00;
  bit line_j = 1'b1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  // per-cycle compare against the expectation recorded for this cycle
  always @(negedge clock) begin
    if (cyc < NCYC) begin
      chk("out_valid", out_valid, exp_v[cyc]);
      chk("rx_sending", rx_sending, exp_s[cyc]);
      chk("pkt_done", pkt_done, exp_d[cyc]);
      chk("rx_error", rx_error, exp_e[cyc]);
      if (exp_v[cyc]) chk("out_bit", out_bit, exp_b[cyc]);
    end
    if (out_valid === 1'b1) begin
      n_valid++;
      cap = {out_bit, cap[7:1]};
    end
    if (pkt_done === 1'b1) n_done++;
    if (rx_error === 1'b1) n_err++;
  end

  task automatic set_exp(input int i, input bit v, input bit b, input bit s, input bit d, input bit e);
    if (i < NCYC) begin
      exp_v[i] = v; exp_b[i] = b; exp_s[i] = s; exp_d[i] = d; exp_e[i] = e;
    end
  endtask

  // drive one bus symbol; its effect is visible two clocks later
  task automatic put(input logic [1:0] sym, input bit v, input bit b, input bit s, input bit d, input bit e);
    @(negedge clock);
    {DP, DM} = sym;
    set_exp(cyc + 2, v, b, s, d, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(SJ, 0, 0, 0, 0, 0);
    line_j = 1'b1;
  endtask

  // KJKJKJKK decodes as 0000000 then 1; DATA is entered on the last one
  task automatic send_sync();
    for (int i = 0; i < 8; i++)
      put((i % 2 == 1 || i == 7) ? ((i == 7) ? SK : SJ) : SK, EMIT, (i == 7), (i == 7), 0, 0);
    line_j = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      if (!data[i]) line_j = ~line_j;
      put(line_j ? SJ : SK, 1, data[i], 1, 0, 0);
    end
  endtask

  task automatic send_eop();
    put(S0, 0, 0, 0, 0, 0);
    put(S0, 0, 0, 0, 0, 0);
    put(SJ, 0, 0, 0, 1, 0);
    line_j = 1'b1;
  endtask

  task automatic mark();
    @(negedge clock); #1;
    b_v = n_valid; b_d = n_done; b_e = n_err;
  endtask

  task automatic check_delta(input string nm, input int dv, input int dd, input int de);
    @(negedge clock); #1;
    chk({nm, "_nvalid"}, n_valid - b_v, dv);
    chk({nm, "_ndone"}, n_done - b_d, dd);
    chk({nm, "_nerr"}, n_err - b_e, de);
    $display("scenario %s: valid=%0d done=%0d err=%0d", nm, n_valid - b_v, n_done - b_d, n_err - b_e);
  endtask

  initial begin
    reset_n = 1'b1; DP = 1'b1; DM = 1'b0; rx_enable = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_rx_sending", rx_sending, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_rx_error", rx_error, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // clean 0xC3 packet
    idle(4); mark();
    send_sync(); send_bits(32'hC3, 8); send_eop();
    idle(4); check_delta("c3", SV + 8, 1, 0);
    chk("c3_bits", cap, 8'hC3);

    // corrupted sync KJKJJ, 7 J then K (count restarts), 8 J, good packet
    idle(2); mark();
    put(SK, EMIT, 0, 0, 0, 0); put(SJ, EMIT, 0, 0, 0, 0);
    put(SK, EMIT, 0, 0, 0, 0); put(SJ, EMIT, 0, 0, 0, 0);
    put(SJ, 0, 0, 0, 0, 1);
    idle(7); put(SK, 0, 0, 0, 0, 0); idle(8);
    send_sync(); send_bits(32'h5A, 8); send_eop();
    idle(4); check_delta("badsync", SV / 2 + SV + 8, 1, 1);
    chk("badsync_bits", cap, 8'h5A);

    // SE1 mid-DATA
    idle(2); mark();
    send_sync(); send_bits(32'h5, 3);
    put(S1, 0, 0, 0, 0, 1);
    idle(10); check_delta("se1", SV + 3, 0, 1);

    // exactly MAX_BITS data bits is a good packet
    idle(2); mark();
    send_sync(); send_bits(32'hB38E, 16); send_eop();
    idle(4); check_delta("max16", SV + 16, 1, 0);

    // one bit over MAX_BITS: 16 emitted, 17th flagged
    idle(2); mark();
    send_sync(); send_bits(32'h1_6C2D, 16);
    line_j = ~line_j;
    put(line_j ? SJ : SK, 0, 0, 0, 0, 1);
    idle(10); check_delta("over17", SV + 16, 0, 1);

    // rx_enable dropped mid-DATA, then a clean packet after re-enable
    idle(2); mark();
    send_sync(); send_bits(32'hF, 4);
    @(negedge clock);
    rx_enable = 1'b0; {DP, DM} = SJ;
    set_exp(cyc + 1, 0, 0, 0, 0, 0);
    set_exp(cyc + 2, 0, 0, 0, 0, 0);
    put(SK, 0, 0, 0, 0, 0); put(S0, 0, 0, 0, 0, 0); put(S1, 0, 0, 0, 0, 0);
    put(SK, 0, 0, 0, 0, 0); idle(2);
    @(negedge clock);
    rx_enable = 1'b1; {DP, DM} = SJ;
    set_exp(cyc + 2, 0, 0, 0, 0, 0);
    idle(2);
    send_sync(); send_bits(32'hC3, 8); send_eop();
    idle(4); check_delta("rxen", SV + 3 + SV + 8, 1, 0);

    // asynchronous reset mid-packet, then a clean packet
    idle(2); mark();
    send_sync(); send_bits(32'h3, 3);
    @(negedge clock); #2;
    reset_n = 1'b0; {DP, DM} = SJ;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_rx_sending", rx_sending, 0);
    chk("arst_out_bit", out_bit, 0);
    chk("arst_pkt_done", pkt_done, 0);
    chk("arst_rx_error", rx_error, 0);
    set_exp(cyc + 1, 0, 0, 0, 0, 0);
    set_exp(cyc + 2, 0, 0, 0, 0, 0);
    idle(3);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    send_sync(); send_bits(32'hC3, 8); send_eop();
    idle(4); check_delta("arst", SV + 2 + SV + 8, 1, 0);
    chk("arst_bits", cap, 8'hC3);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
